// File: rtl/sync_receiver_pkg.sv
// Shared definitions for the clocked request/acknowledge link:
// the default word width and the link state encoding used by both ends.
package sync_receiver_pkg;

    localparam int unsigned B_DEFAULT = 16;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } link_state_e;

endpackage

// File: rtl/sync_receiver.sv
// Receiving half of a single-clock request/acknowledge link: captures BusData
// when rqst and enr coincide in IDLE and answers with a one-cycle ack pulse.
module sync_receiver
    import sync_receiver_pkg::*;
#(
    parameter int unsigned B = B_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rqst,
    input  logic         enr,
    input  logic [B-1:0] BusData,
    output logic         ack,
    output logic [B-1:0] OutData,
    output link_state_e  state_dbg
);

    // Handshake: a word transfers on a rising edge where the FSM is in IDLE and
    // rqst=1 (sender valid) and enr=1 (receiver ready); ack is high for the one
    // cycle after that edge, during which no further capture can happen.
    link_state_e  state_q, state_d;
    logic         ack_q, ack_d;
    logic [B-1:0] out_data_q, out_data_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ack_q      <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            out_data_q <= out_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ack_d      = 1'b0;
        out_data_d = out_data_q;
        case (state_q)
            IDLE: begin
                if (rqst && enr) begin
                    out_data_d = BusData;
                    ack_d      = 1'b1;
                    state_d    = ACK;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign ack       = ack_q;
    assign OutData   = out_data_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_sync_receiver.sv
// Bench for sync_receiver: a vector table plus hand-written sequences for
// stall, streaming and reset cases, checked through an expected queue.
module tb_sync_receiver;
    import sync_receiver_pkg::*;

    localparam int B = 16;
    localparam int W = B + 2;

    logic         clk;
    logic         rst;
    logic         rqst;
    logic         enr;
    logic [B-1:0] bus_data;
    logic         ack;
    logic [B-1:0] out_data;
    link_state_e  state_dbg;

    int checks = 0;
    int errors = 0;

    // Entry layout: {state is ACK, ack, OutData}.
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic         rqst;
        logic         enr;
        logic [B-1:0] data;
        logic         exp_ack;
        logic [B-1:0] exp_out;
    } vec_t;

    vec_t vecs[13];

    sync_receiver #(.B(B)) dut (
        .clk       (clk),
        .rst       (rst),
        .rqst      (rqst),
        .enr       (enr),
        .BusData   (bus_data),
        .ack       (ack),
        .OutData   (out_data),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] observed();
        return {state_dbg == ACK, ack, out_data};
    endfunction

    task automatic check_now(input string name, input logic [W-1:0] exp);
        logic [W-1:0] got;
        got = observed();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Called at a falling edge: drive, push expectation, take one rising edge,
    // then compare at the next falling edge.
    task automatic cycle(input logic r, input logic e, input logic [B-1:0] d,
                         input logic exp_ack, input logic [B-1:0] exp_out,
                         input string name);
        logic [W-1:0] exp;
        logic [W-1:0] got;
        rqst     = r;
        enr      = e;
        bus_data = d;
        exp_q.push_back({exp_ack, exp_ack, exp_out});
        @(posedge clk);
        @(negedge clk);
        got = observed();
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s got %h expected <empty queue>", name, got);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                errors++;
                $display("FAIL %s got %h expected %h", name, got, exp);
            end
        end
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 16'h1234, 1'b0, 16'h0000};
        vecs[1]  = '{1'b1, 1'b0, 16'hABCD, 1'b0, 16'h0000};
        vecs[2]  = '{1'b0, 1'b1, 16'h1111, 1'b0, 16'h0000};
        vecs[3]  = '{1'b1, 1'b1, 16'hCAFD, 1'b1, 16'hCAFD};
        vecs[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'hCAFD};
        vecs[5]  = '{1'b1, 1'b1, 16'h5555, 1'b1, 16'h5555};
        vecs[6]  = '{1'b1, 1'b1, 16'h6666, 1'b0, 16'h5555};
        vecs[7]  = '{1'b1, 1'b1, 16'h6666, 1'b1, 16'h6666};
        vecs[8]  = '{1'b0, 1'b1, 16'h7777, 1'b0, 16'h6666};
        vecs[9]  = '{1'b1, 1'b1, 16'hFFFF, 1'b1, 16'hFFFF};
        vecs[10] = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'hFFFF};
        vecs[11] = '{1'b1, 1'b1, 16'h0000, 1'b1, 16'h0000};
        vecs[12] = '{1'b0, 1'b0, 16'h9999, 1'b0, 16'h0000};

        // Reset asserted with a pending request: outputs clear at once, no capture.
        rst      = 1'b1;
        rqst     = 1'b1;
        enr      = 1'b1;
        bus_data = 16'hFFFF;
        #1;
        check_now("reset_immediate", {1'b0, 1'b0, 16'h0000});
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_now("reset_held_no_capture", {1'b0, 1'b0, 16'h0000});
        rst  = 1'b0;
        rqst = 1'b0;
        enr  = 1'b0;

        for (int i = 0; i < 13; i++) begin
            cycle(vecs[i].rqst, vecs[i].enr, vecs[i].data,
                  vecs[i].exp_ack, vecs[i].exp_out, $sformatf("vec%0d", i));
        end

        // Receiver stalled for 5 cycles with a pending word.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 16'h0005, 1'b0, 16'h0000, $sformatf("stall%0d", i));
        end
        cycle(1'b1, 1'b1, 16'h0005, 1'b1, 16'h0005, "stall_release");
        cycle(1'b0, 1'b1, 16'h0005, 1'b0, 16'h0005, "stall_after");

        // Streaming: sender advances BusData on each ack.
        begin
            logic [B-1:0] word;
            word = '0;
            for (int k = 0; k < 16; k++) begin
                logic [B-1:0] exp_word;
                exp_word = B'(k / 2);
                cycle(1'b1, 1'b1, word, (k % 2) == 0, exp_word,
                      $sformatf("stream%0d", k));
                if (ack) word = word + 1'b1;
            end
        end
        cycle(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0007, "stream_idle");

        // Random-data single transfers, each followed by an idle cycle.
        for (int i = 0; i < 8; i++) begin
            logic [B-1:0] d;
            d = B'($urandom_range(0, 16'hFFFF));
            cycle(1'b1, 1'b1, d, 1'b1, d, $sformatf("rand_cap%0d", i));
            cycle(1'b0, 1'b0, ~d, 1'b0, d, $sformatf("rand_hold%0d", i));
        end

        // Reset pulsed mid-cycle while ack is high.
        cycle(1'b1, 1'b1, 16'hBEEF, 1'b1, 16'hBEEF, "pre_reset_cap");
        #2;
        rst = 1'b1;
        #1;
        check_now("reset_mid_ack", {1'b0, 1'b0, 16'h0000});
        @(posedge clk);
        @(negedge clk);
        check_now("reset_mid_held", {1'b0, 1'b0, 16'h0000});
        rst = 1'b0;
        cycle(1'b1, 1'b1, 16'h1234, 1'b1, 16'h1234, "post_reset_cap");
        cycle(1'b0, 1'b0, 16'h0000, 1'b0, 16'h1234, "post_reset_idle");

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL queue_drain got %0d entries expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
